prco_regs_ctrl: RTL
===================

# prco_regs_ctrl

Access controller for the PRCO register set. Sits between the register file and its two clients: the core execute stage, which has priority, and the debug/loader port. After reset it runs an 8-cycle initialisation sequence that writes every register. It then time-shares the file's read and write ports, stalling the core whenever a debug access is being served.

## Interface
Parameters:
- SP_INIT, 16'h00FF: value written to `REG_SP during init.
- BP_INIT, 16'h00FF: value written to `REG_BP during init.
- STARVE_MAX, 4'd15: pending-debug cycles before a debug grant is forced (only with PRCO_REGS_CTRL_STARVE_EN).

Ports:
- i_clk  in  1  sole clock, rising edge.
- i_reset_n  in  1  synchronous, active-low reset.
- i_core_valid  in  1  core wants a register-file access this cycle.
- i_core_sela / i_core_selb  in  3  core read selects.
- i_core_we  in  1  core write enable.
- i_core_seld  in  3  core write select.
- i_core_datd  in  16  core write data.
- q_core_stall  out  1  core access not performed this cycle; core must hold its request.
- i_dbg_req  in  1  debug request, held until q_dbg_ack.
- i_dbg_we  in  1  1 = write, 0 = read.
- i_dbg_sel  in  3  debug register index.
- i_dbg_wdata  in  16  debug write data.
- q_dbg_ack  out  1  one-cycle completion pulse.
- q_dbg_rdata  out  16  read result, valid while q_dbg_ack is 1 and held afterwards.
- q_rf_en  out  1  register-file enable.
- q_rf_sela / q_rf_selb  out  3  register-file read selects.
- q_rf_we  out  1  register-file write enable.
- q_rf_seld  out  3  register-file write select.
- q_rf_datd  out  16  register-file write data.
- i_rf_data  in  16  register-file port A output (registered in the file, 1-cycle latency).
- q_init_done  out  1  initialisation sequence complete.

## Operation
- States: INIT, CORE, DBG_WR, DBG_RD, DBG_CAP.
- Reset values (i_reset_n = 0 at an edge): state INIT, init counter 0, q_init_done 0, q_dbg_ack 0, q_dbg_rdata 0, q_core_stall 1, q_rf_we 0, q_rf_en 0.
- INIT:
  - q_rf_en 1, q_rf_we 1, q_rf_seld = counter.
  - Data is SP_INIT at `REG_SP, BP_INIT at `REG_BP, 0 at every other index.
  - Counter 0..7, one register per cycle; after index 7, go to CORE and set q_init_done to 1.
  - q_core_stall is 1 throughout INIT. A debug request is held pending, not acknowledged.
- CORE:
  - The core fields pass straight to the q_rf_* outputs; q_core_stall 0.
  - q_rf_we = i_core_valid & i_core_we.
  - If i_dbg_req is 1 and i_core_valid is 0, grant debug: go to DBG_WR or DBG_RD according to i_dbg_we.
- DBG_WR: drive q_rf_we 1, q_rf_seld = i_dbg_sel, q_rf_datd = i_dbg_wdata; q_core_stall 1; next state CORE with q_dbg_ack 1 in that cycle.
- DBG_RD: q_rf_sela = i_dbg_sel, q_rf_we 0, q_core_stall 1; next state DBG_CAP.
- DBG_CAP: q_core_stall 1; at the end of the cycle, q_dbg_rdata ← i_rf_data; next state CORE with q_dbg_ack 1.
- After q_dbg_ack, the requester drops i_dbg_req in the following cycle. A req still high two cycles after ack is a new request.
- A debug write and a core read of the same register never overlap, because the core is stalled during every DBG state.
- Reset asserted in any state aborts the access and returns to INIT. A pending debug request is dropped without ack.

## Timing
- Init: q_init_done rises 8 cycles after the first edge with i_reset_n = 1.
- Debug write: grant in cycle N, register written at the end of N, ack in N+1; the core is stalled for 1 cycle.
- Debug read: grant in cycle N, ack and data in N+2; the core is stalled for 2 cycles.
- Core read: data arrives from the register file 1 cycle after selects are presented. The controller adds no latency.

## Configuration
- PRCO_REGS_CTRL_STARVE_EN defined:
  - A 4-bit counter increments each cycle in CORE while i_dbg_req is 1 and i_core_valid is 1.
  - When it reaches STARVE_MAX, debug is granted regardless of i_core_valid, with q_core_stall 1.
  - The counter clears on any debug grant and on reset.
- Not defined: debug is served only in cycles where i_core_valid is 0, and may starve indefinitely.

## Structure
- prco_constants: `REG_SP and `REG_BP indices, and the state encodings (PRCO_RC_INIT and the others).
- One sub-module, prco_starve_cnt (counter plus terminal flag), instantiated only under PRCO_REGS_CTRL_STARVE_EN.

## Test plan
- Reset release: r0..r5 = 16'h0000, r6/r7 per `REG_SP/`REG_BP = 16'h00FF; q_init_done 1 at cycle 8; q_core_stall 1 for cycles 0..7.
- Core idle, debug write r3 = 16'hBEEF, then debug read r3: first ack one cycle after grant; read ack two cycles after grant with q_dbg_rdata = 16'hBEEF.
- i_core_valid held at 1 with debug req pending, STARVE_EN defined: grant on cycle 15 of pending, core stalled for 2 cycles, read completes.
- Same stimulus with STARVE_EN undefined: no ack while i_core_valid is 1; ack follows the first cycle with i_core_valid = 0.
- Debug request raised during INIT: no ack before q_init_done; served immediately after INIT.
- i_reset_n pulsed low during DBG_RD: no ack, q_dbg_rdata = 0, init sequence restarts and completes 8 cycles later.

Source files
------------

// File: rtl/prco_regs_ctrl_pkg.sv
// prco_regs_ctrl_pkg: register indices, controller state encodings and init values
// for the PRCO register-file access controller.
package prco_regs_ctrl_pkg;

    localparam logic [2:0] REG_SP = 3'd6;
    localparam logic [2:0] REG_BP = 3'd7;

    localparam logic [2:0] PRCO_RC_INIT    = 3'd0;
    localparam logic [2:0] PRCO_RC_CORE    = 3'd1;
    localparam logic [2:0] PRCO_RC_DBG_WR  = 3'd2;
    localparam logic [2:0] PRCO_RC_DBG_RD  = 3'd3;
    localparam logic [2:0] PRCO_RC_DBG_CAP = 3'd4;

    function automatic logic [15:0] init_value(input logic [2:0] idx, input logic [15:0] sp,
                                               input logic [15:0] bp);
        return idx == REG_SP ? sp : idx == REG_BP ? bp : 16'h0000;
    endfunction

endpackage

// File: rtl/prco_regs_ctrl_starve_cnt.sv
// prco_starve_cnt: counts cycles a debug request waits behind the core and flags
// when the wait reaches MAX.
module prco_starve_cnt #(
    parameter logic [3:0] MAX = 4'd15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic hit
);

    logic [3:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clr)
            cnt <= 4'd0;
        else if (inc)
            cnt <= cnt + 4'd1;
    end

    assign hit = cnt == MAX;

endmodule

// File: rtl/prco_regs_ctrl.sv
// prco_regs_ctrl: register-file access controller (init sequence, core/debug arbitration).
// Optional forced debug grant after starvation under PRCO_REGS_CTRL_STARVE_EN.
module prco_regs_ctrl
    import prco_regs_ctrl_pkg::*;
#(
    parameter logic [15:0] SP_INIT    = 16'h00FF,
    parameter logic [15:0] BP_INIT    = 16'h00FF,
    parameter logic [3:0]  STARVE_MAX = 4'd15
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_core_valid,
    input  logic [2:0]  i_core_sela,
    input  logic [2:0]  i_core_selb,
    input  logic        i_core_we,
    input  logic [2:0]  i_core_seld,
    input  logic [15:0] i_core_datd,
    output logic        q_core_stall,
    input  logic        i_dbg_req,
    input  logic        i_dbg_we,
    input  logic [2:0]  i_dbg_sel,
    input  logic [15:0] i_dbg_wdata,
    output logic        q_dbg_ack,
    output logic [15:0] q_dbg_rdata,
    output logic        q_rf_en,
    output logic [2:0]  q_rf_sela,
    output logic [2:0]  q_rf_selb,
    output logic        q_rf_we,
    output logic [2:0]  q_rf_seld,
    output logic [15:0] q_rf_datd,
    input  logic [15:0] i_rf_data,
    output logic        q_init_done
);

    logic [2:0] state, state_nxt, init_cnt;
    logic       in_init, in_core, in_wr, in_rd, in_cap;
    logic       starve_hit, grant;

    assign in_init = state == PRCO_RC_INIT;
    assign in_core = state == PRCO_RC_CORE;
    assign in_wr   = state == PRCO_RC_DBG_WR;
    assign in_rd   = state == PRCO_RC_DBG_RD;
    assign in_cap  = state == PRCO_RC_DBG_CAP;

    // The ack cycle still sees the old request, so it must not re-grant.
    assign grant = in_core && i_dbg_req && !q_dbg_ack && (!i_core_valid || starve_hit);

`ifdef PRCO_REGS_CTRL_STARVE_EN
    prco_starve_cnt #(.MAX(STARVE_MAX)) u_starve (
        .clk   (i_clk),
        .rst_n (i_reset_n),
        .inc   (in_core && i_dbg_req && !q_dbg_ack && i_core_valid),
        .clr   (grant),
        .hit   (starve_hit)
    );
`else
    logic unused_starve_max;
    assign unused_starve_max = ^STARVE_MAX;
    assign starve_hit = 1'b0;
`endif

    always_comb
        state_nxt = in_init ? (init_cnt == 3'd7 ? PRCO_RC_CORE : PRCO_RC_INIT) :
                    in_core ? (grant ? (i_dbg_we ? PRCO_RC_DBG_WR : PRCO_RC_DBG_RD) : PRCO_RC_CORE) :
                    in_rd   ? PRCO_RC_DBG_CAP : PRCO_RC_CORE;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state       <= PRCO_RC_INIT;
            init_cnt    <= 3'd0;
            q_init_done <= 1'b0;
            q_dbg_ack   <= 1'b0;
            q_dbg_rdata <= 16'h0000;
        end else begin
            state       <= state_nxt;
            init_cnt    <= in_init ? init_cnt + 3'd1 : init_cnt;
            q_init_done <= q_init_done || (in_init && init_cnt == 3'd7);
            q_dbg_ack   <= in_wr || in_cap;
            if (in_cap)
                q_dbg_rdata <= i_rf_data;
        end
    end

    // Enables are gated by reset so nothing is written while reset is held.
    assign q_core_stall = !i_reset_n || !in_core;
    assign q_rf_en   = i_reset_n && (in_init || in_wr || in_rd || (in_core && i_core_valid));
    assign q_rf_we   = i_reset_n && (in_init || in_wr || (in_core && i_core_valid && i_core_we));
    assign q_rf_sela = in_rd ? i_dbg_sel : i_core_sela;
    assign q_rf_selb = i_core_selb;
    assign q_rf_seld = in_init ? init_cnt : in_wr ? i_dbg_sel : i_core_seld;
    assign q_rf_datd = in_init ? init_value(init_cnt, SP_INIT, BP_INIT) :
                       in_wr   ? i_dbg_wdata : i_core_datd;

endmodule
